// File: rtl/pulse_cfg_pkg.sv
// Shared types and constants for the pulse parameter loader.
// Command IDs, response bytes, reset defaults and the parameter-set struct.
package pulse_cfg_pkg;

  localparam logic [7:0] CMD_PERIOD = 8'h01;
  localparam logic [7:0] CMD_P1W    = 8'h02;
  localparam logic [7:0] CMD_P2W    = 8'h03;
  localparam logic [7:0] CMD_PBW    = 8'h04;
  localparam logic [7:0] CMD_DELAY  = 8'h05;
  localparam logic [7:0] CMD_OFFRES = 8'h06;
  localparam logic [7:0] CMD_ATTDLY = 8'h07;
  localparam logic [7:0] CMD_FLAGS  = 8'h08;
  localparam logic [7:0] CMD_ATTN   = 8'h09;
  localparam logic [7:0] CMD_COMMIT = 8'h0A;

  localparam logic [7:0] ACK_DEF = 8'h06;
  localparam logic [7:0] NAK_DEF = 8'h15;

  localparam logic [31:0] RST_PERIOD  = 32'd20000;
  localparam logic [31:0] RST_P1W     = 32'd30;
  localparam logic [31:0] RST_P2W     = 32'd60;
  localparam logic [31:0] RST_PBW     = 32'd30;
  localparam logic [31:0] RST_DELAY   = 32'd200;
  localparam logic [31:0] RST_OFFRES  = 32'd19470;
  localparam logic [31:0] RST_ATTDLY  = 32'd2000;
  localparam logic [31:0] RST_P2START = 32'd230;
  localparam logic [31:0] RST_SYNC    = 32'd290;
  localparam logic [31:0] RST_ATTDOWN = 32'd2290;
  localparam logic [7:0]  RST_PBLOCK  = 8'd50;
  localparam logic [6:0]  RST_PPPUMP  = 7'h00;
  localparam logic [6:0]  RST_PPPROBE = 7'h7F;
  localparam logic [6:0]  RST_POSTATT = 7'h7F;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] p1width;
    logic [31:0] p2width;
    logic [31:0] pbwidth;
    logic [31:0] delay;
    logic [31:0] offres_delay;
    logic [31:0] att_delay;
    logic [31:0] p2start;
    logic [31:0] sync_up;
    logic [31:0] att_down;
    logic        pump;
    logic        double;
    logic        block;
    logic [7:0]  pulse_block;
    logic [6:0]  pp_pump;
    logic [6:0]  pp_probe;
    logic [6:0]  post_att;
  } pulse_cfg_t;

  localparam pulse_cfg_t CFG_RESET = '{
    period:       RST_PERIOD,
    p1width:      RST_P1W,
    p2width:      RST_P2W,
    pbwidth:      RST_PBW,
    delay:        RST_DELAY,
    offres_delay: RST_OFFRES,
    att_delay:    RST_ATTDLY,
    p2start:      RST_P2START,
    sync_up:      RST_SYNC,
    att_down:     RST_ATTDOWN,
    pump:         1'b1,
    double:       1'b1,
    block:        1'b1,
    pulse_block:  RST_PBLOCK,
    pp_pump:      RST_PPPUMP,
    pp_probe:     RST_PPPROBE,
    post_att:     RST_POSTATT
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CHECK,
    ST_RESP
  } ld_state_e;

  function automatic logic is_write_cmd(
    input logic [7:0] cmd
  );
    return (cmd >= CMD_PERIOD) &&
           (cmd <= CMD_ATTN);
  endfunction

  // Apply one assembled payload word to
  // the field selected by the command.
  function automatic pulse_cfg_t cfg_write(
    input pulse_cfg_t  c,
    input logic [7:0]  cmd,
    input logic [31:0] w
  );
    pulse_cfg_t r;
    r = c;
    case (cmd)
      CMD_PERIOD: r.period       = w;
      CMD_P1W:    r.p1width      = w;
      CMD_P2W:    r.p2width      = w;
      CMD_PBW:    r.pbwidth      = w;
      CMD_DELAY:  r.delay        = w;
      CMD_OFFRES: r.offres_delay = w;
      CMD_ATTDLY: r.att_delay    = w;
      CMD_FLAGS: begin
        r.pump        = w[0];
        r.double      = w[1];
        r.block       = w[2];
        r.pulse_block = w[15:8];
      end
      CMD_ATTN: begin
        r.pp_pump  = w[6:0];
        r.pp_probe = w[14:8];
        r.post_att = w[22:16];
      end
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pulse_param_check.sv
// Derived timing and validity of a candidate parameter set.
// Inputs: the six timing words; outputs: p2start/sync_up/att_down, valid.
module pulse_param_check
  import pulse_cfg_pkg::*;
(
  input  logic [31:0] period_i,
  input  logic [31:0] p1width_i,
  input  logic [31:0] p2width_i,
  input  logic [31:0] delay_i,
  input  logic [31:0] offres_i,
  input  logic [31:0] att_delay_i,
  output logic [31:0] p2start_o,
  output logic [31:0] sync_up_o,
  output logic [31:0] att_down_o,
  output logic        valid_o
);

  logic [32:0] s_p2;
  logic [32:0] s_sync;
  logic [32:0] s_att;
  logic [32:0] s_off;
  logic        carry;

  // 33-bit sums so that any wrap of the
  // 32-bit results shows up in bit 32.
  always_comb begin
    s_p2   = {1'b0, p1width_i}
           + {1'b0, delay_i};
    s_sync = {1'b0, s_p2[31:0]}
           + {1'b0, p2width_i};
    s_att  = {1'b0, s_sync[31:0]}
           + {1'b0, att_delay_i};
    s_off  = {1'b0, offres_i}
           + {1'b0, p1width_i};
    carry  = s_p2[32] | s_sync[32]
           | s_att[32] | s_off[32];
  end

  assign p2start_o  = s_p2[31:0];
  assign sync_up_o  = s_sync[31:0];
  assign att_down_o = s_att[31:0];

  assign valid_o = (p1width_i != '0)
                && (period_i > s_att[31:0])
                && (s_off[31:0] < period_i)
                && !carry;

endmodule

// File: rtl/pulse_param_loader.sv
// Host command parser that stages pulse parameters and applies them
// only at a pulse-period boundary, answering each frame ACK/NAK.
// Ports: clk_pll/resetn; rx_data/rx_valid in; tx_data/tx_valid/tx_ready;
// cycle_start in; active timing, derived, flag and attenuator outputs;
// pending = validated set waiting for the next cycle_start.
module pulse_param_loader
  import pulse_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1200000,
  parameter logic [7:0]  ACK_BYTE       = ACK_DEF,
  parameter logic [7:0]  NAK_BYTE       = NAK_DEF
) (
  input  logic        clk_pll,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        cycle_start,
  output logic [31:0] period,
  output logic [31:0] p1width,
  output logic [31:0] p2width,
  output logic [31:0] pbwidth,
  output logic [31:0] delay,
  output logic [31:0] offres_delay,
  output logic [31:0] p2start,
  output logic [31:0] sync_up,
  output logic [31:0] att_down,
  output logic        pump,
  output logic        double,
  output logic        block,
  output logic [7:0]  pulse_block,
  output logic [6:0]  pp_pump,
  output logic [6:0]  pp_probe,
  output logic [6:0]  post_att,
  output logic        pending
);

  localparam logic [31:0] TO_LAST =
    32'(TIMEOUT_CYCLES - 1);

  ld_state_e   state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] idle_q, idle_d;
  pulse_cfg_t  shadow_q, shadow_d;
  pulse_cfg_t  staged_q, staged_d;
  pulse_cfg_t  active_q, active_d;
  logic        pending_q, pending_d;
  logic        txv_q, txv_d;
  logic [7:0]  txd_q, txd_d;

  logic [31:0] chk_p2start;
  logic [31:0] chk_sync;
  logic [31:0] chk_att;
  logic        chk_valid;

  pulse_param_check u_check (
    .period_i    (shadow_q.period),
    .p1width_i   (shadow_q.p1width),
    .p2width_i   (shadow_q.p2width),
    .delay_i     (shadow_q.delay),
    .offres_i    (shadow_q.offres_delay),
    .att_delay_i (shadow_q.att_delay),
    .p2start_o   (chk_p2start),
    .sync_up_o   (chk_sync),
    .att_down_o  (chk_att),
    .valid_o     (chk_valid)
  );

  always_ff @(posedge clk_pll or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      idle_q    <= '0;
      shadow_q  <= CFG_RESET;
      staged_q  <= CFG_RESET;
      active_q  <= CFG_RESET;
      pending_q <= 1'b0;
      txv_q     <= 1'b0;
      txd_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      idle_q    <= idle_d;
      shadow_q  <= shadow_d;
      staged_q  <= staged_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      txv_q     <= txv_d;
      txd_q     <= txd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    idle_d    = idle_q;
    shadow_d  = shadow_q;
    staged_d  = staged_q;
    active_d  = active_q;
    pending_d = pending_q;
    txv_d     = txv_q;
    txd_d     = txd_q;

    // Apply reads staged_q, so a commit in
    // the same cycle lands as the next set.
    if (cycle_start && pending_q) begin
      active_d  = staged_q;
      pending_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (is_write_cmd(rx_data)) begin
            cmd_d   = rx_data;
            cnt_d   = '0;
            word_d  = '0;
            idle_d  = '0;
            state_d = ST_PAYLOAD;
          end else if (rx_data == CMD_COMMIT) begin
            state_d = ST_CHECK;
          end else begin
            txd_d   = NAK_BYTE;
            txv_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_PAYLOAD: begin
        if (rx_valid) begin
          word_d[{cnt_q, 3'b000} +: 8] = rx_data;
          cnt_d  = cnt_q + 2'd1;
          idle_d = '0;
          if (cnt_q == 2'd3) begin
            shadow_d = cfg_write(
              shadow_q, cmd_q,
              {rx_data, word_q[23:0]});
            txd_d   = ACK_BYTE;
            txv_d   = 1'b1;
            state_d = ST_RESP;
          end
        end else if (idle_q >= TO_LAST) begin
          txd_d   = NAK_BYTE;
          txv_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end

      ST_CHECK: begin
        if (chk_valid) begin
          staged_d          = shadow_q;
          staged_d.p2start  = chk_p2start;
          staged_d.sync_up  = chk_sync;
          staged_d.att_down = chk_att;
          pending_d         = 1'b1;
          txd_d             = ACK_BYTE;
        end else begin
          txd_d = NAK_BYTE;
        end
        txv_d   = 1'b1;
        state_d = ST_RESP;
      end

      ST_RESP: begin
        if (tx_ready) begin
          txv_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // att_delay only feeds the derived values.
  logic unused_att;
  assign unused_att = ^active_q.att_delay;

  assign tx_data      = txd_q;
  assign tx_valid     = txv_q;
  assign pending      = pending_q;
  assign period       = active_q.period;
  assign p1width      = active_q.p1width;
  assign p2width      = active_q.p2width;
  assign pbwidth      = active_q.pbwidth;
  assign delay        = active_q.delay;
  assign offres_delay = active_q.offres_delay;
  assign p2start      = active_q.p2start;
  assign sync_up      = active_q.sync_up;
  assign att_down     = active_q.att_down;
  assign pump         = active_q.pump;
  assign double       = active_q.double;
  assign block        = active_q.block;
  assign pulse_block  = active_q.pulse_block;
  assign pp_pump      = active_q.pp_pump;
  assign pp_probe     = active_q.pp_probe;
  assign post_att     = active_q.post_att;

endmodule

// File: doc/pulse_param_loader.md
Name: pulse_param_loader

Overview:
- Host-facing configuration controller for the `pulses` generator.
- Consumes a decoded UART byte stream and parses framed write/commit commands into shadow registers.
- Validates a committed set, computes derived timing (p2start, sync_up, att_down) and swaps the set into the active outputs only at a pulse-period boundary, so a period never runs on mixed parameters.
- Answers every frame with a one-byte ACK/NAK on the UART TX handshake.

Parameters:
- TIMEOUT_CYCLES, 32'd1200000, max idle clk_pll cycles between bytes of one frame before abort (10 ms at 120 MHz).
- ACK_BYTE, 8'h06, response for an accepted frame.
- NAK_BYTE, 8'h15, response for a rejected, unknown or timed-out frame.

Ports:
- clk_pll  in  1  sole clock.
- resetn  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  8  response byte.
- tx_valid  out  1  response pending; held until accepted.
- tx_ready  in  1  UART TX accepts tx_data when high with tx_valid.
- cycle_start  in  1  one-cycle strobe from `pulses` at period counter wrap.
- period, p1width, p2width, pbwidth, delay, offres_delay  out  32 each  active timing values.
- p2start, sync_up, att_down  out  32 each  active derived timing.
- pump, double, block  out  1 each  active mode flags.
- pulse_block  out  8  active block count.
- pp_pump, pp_probe, post_att  out  7 each  active attenuator codes.
- pending  out  1  staged set awaiting cycle_start.

Behaviour:
- Frame format: cmd byte, then 4 payload bytes, little-endian. Commit (0x0A) has no payload.
- Command IDs:
  - 0x01 period; 0x02 p1width; 0x03 p2width; 0x04 pbwidth; 0x05 delay; 0x06 offres_delay; 0x07 att_delay (internal shadow only).
  - 0x08 flags: bit0 pump, bit1 double, bit2 block, bits15:8 pulse_block.
  - 0x09 attenuators: [6:0] pp_pump, [14:8] pp_probe, [22:16] post_att.
  - 0x0A commit.
- Reset values (active, shadow and staged alike):
  - period 20000; p1width 30; p2width 60; pbwidth 30; delay 200; att_delay 2000.
  - p2start 230; sync_up 290; att_down 2290; offres_delay 19470.
  - pump 1; double 1; block 1; pulse_block 50.
  - pp_pump 7'h00; pp_probe 7'h7F; post_att 7'h7F.
  - pending 0; tx_valid 0; tx_data 0; FSM in IDLE.
- FSM states:
  - IDLE: on rx_valid:
    - cmd 0x01–0x09: latch cmd, byte count := 0, go PAYLOAD.
    - cmd 0x0A: go CHECK.
    - any other cmd: NAK, go RESP.
  - PAYLOAD: each rx_valid shifts a byte into bits [8k+7:8k]. After byte 3, write the shadow register, ACK, go RESP. If the idle counter reaches TIMEOUT_CYCLES: discard the frame, NAK, go RESP.
  - CHECK (1 cycle): from shadow, compute d_p2start = p1width+delay, d_sync = d_p2start+p2width, d_att = d_sync+att_delay, all modulo 2^32.
    - Valid iff p1width != 0, period > d_att, offres_delay + p1width < period, and no carry out of any sum.
    - Valid: copy shadow plus derived values to staged, set pending, ACK.
    - Invalid: NAK; staged and pending unchanged.
    - Go RESP.
  - RESP: tx_valid=1. Return to IDLE on the cycle tx_valid && tx_ready. rx bytes arriving in RESP are dropped.
- Apply: on cycle_start with pending=1, active := staged and pending := 0; outputs change the cycle after the strobe.
- Latencies:
  - Last payload byte to tx_valid: 1 cycle.
  - Commit byte to tx_valid: 2 cycles.
  - Commit and cycle_start in the same cycle: apply takes the old staged set; the new set goes pending.
- Shadow writes never affect active or staged until a commit.
- A commit while pending overwrites staged; pending stays 1.
- resetn low at any point (mid-frame, RESP, pending) restores all reset values immediately.

Decomposition:
- Shared package pulse_cfg_pkg holds:
  - command ID constants, ACK/NAK constants;
  - reset-default constants, matching the startup values used elsewhere;
  - a packed struct of the full parameter set (shadow/staged/active use one type).
- One sub-module, pulse_param_check: combinational derived-value and validity computation, instantiated by CHECK.

Test Plan:
- Reset, no traffic → all outputs equal the defaults; p2start=230, att_down=2290; tx_valid=0.
- Write 0x01 40 9C 00 00 (period 40000), commit, tx_ready=1, then pulse cycle_start → ACK twice; pending=1 until cycle_start; period=40000 one cycle after the strobe.
- Write p1width=50 and delay=400, commit, cycle_start → p2start=450, sync_up=510, att_down=2510.
- Write period=1000, commit → NAK (att_down 2290 ≥ 1000); pending stays 0; period still 20000.
- Send 0x02 0x10, then idle TIMEOUT_CYCLES → NAK; p1width shadow unchanged; next frame parses normally. Unknown cmd 0x55 → immediate NAK.
- Hold tx_ready=0 for 50 cycles after a frame → tx_valid and tx_data stable, extra rx bytes dropped. Assert resetn low mid-payload → defaults restored, FSM in IDLE, tx_valid=0.
